memory_arbiter: RTL and testbench

//  Shares one 128-bit block-wide main memory between the instruction-cache refill

---
 rtl/memory_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_memory_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_arbiter.sv
// -----------------------------------------------------------------------------
// memory_arbiter
//   Shares one 128-bit block-wide main memory between the I-cache refill port
//   and the D-cache refill/write-back port. One requester is granted at a time;
//   when both are waiting the side that was not granted last wins. The granted
//   command is registered onto MEM_*. The read block and a busywait handshake
//   go back to the granted cache. A watchdog aborts a transaction that stays in
//   SERVE for MEM_TIMEOUT cycles and raises a sticky TIMEOUT_ERR.
//
// Ports
//   CLK, RESET                      clock, asynchronous active-high reset
//   I_READ, I_ADDRESS               I-cache block read request / address
//   I_READDATA, I_BUSYWAIT          block returned to I-cache, I-side stall
//   D_READ, D_WRITE, D_ADDRESS      D-cache block read / write-back request
//   D_WRITEDATA                     D-cache write-back block
//   D_READDATA, D_BUSYWAIT          block returned to D-cache, D-side stall
//   MEM_READ, MEM_WRITE             registered memory commands
//   MEM_ADDRESS, MEM_WRITEDATA      registered memory address / write block
//   MEM_READDATA, MEM_BUSYWAIT      memory read block / memory busy
//   TIMEOUT_ERR                     sticky watchdog flag
// -----------------------------------------------------------------------------
module memory_arbiter #(
   parameter int MEM_TIMEOUT = 255
) (
   input  logic         CLK,
   input  logic         RESET,
   input  logic         I_READ,
   input  logic [27:0]  I_ADDRESS,
   output logic [127:0] I_READDATA,
   output logic         I_BUSYWAIT,
   input  logic         D_READ,
   input  logic         D_WRITE,
   input  logic [27:0]  D_ADDRESS,
   input  logic [127:0] D_WRITEDATA,
   output logic [127:0] D_READDATA,
   output logic         D_BUSYWAIT,
   output logic         MEM_READ,
   output logic         MEM_WRITE,
   output logic [27:0]  MEM_ADDRESS,
   output logic [127:0] MEM_WRITEDATA,
   input  logic [127:0] MEM_READDATA,
   input  logic         MEM_BUSYWAIT,
   output logic         TIMEOUT_ERR
);

   localparam int CW = $clog2(MEM_TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE = 2'd0, SERVE_I = 2'd1, SERVE_D = 2'd2} state_t;

   state_t         state_q, state_d;
   logic           mem_read_q, mem_read_d;
   logic           mem_write_q, mem_write_d;
   logic [27:0]    mem_addr_q, mem_addr_d;
   logic [127:0]   mem_wdata_q, mem_wdata_d;
   logic [127:0]   i_rdata_q, i_rdata_d;
   logic [127:0]   d_rdata_q, d_rdata_d;
   logic           i_done_q, i_done_d;
   logic           d_done_q, d_done_d;
   logic           started_q, started_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           tmo_q, tmo_d;
   logic           last_d_q, last_d_d;   // 1: D was granted last, 0: I

   logic i_elig, d_elig, grant_i, grant_d;
   logic finish_ok, timeout_hit, done_edge;

   // DONE masks the request for one cycle so a request the cache has not yet
   // dropped is not mistaken for a new one.
   assign i_elig = I_READ & ~i_done_q;
   assign d_elig = (D_READ | D_WRITE) & ~d_done_q;

   assign grant_d = d_elig & (~i_elig | ~last_d_q);
   assign grant_i = i_elig & ~grant_d;

   // Memory must have been seen busy before its falling busywait counts as done.
   assign finish_ok   = started_q & ~MEM_BUSYWAIT;
   // The counter is cleared at grant, so this edge closes MEM_TIMEOUT cycles in SERVE.
   assign timeout_hit = (cnt_q == CW'(MEM_TIMEOUT - 1));
   assign done_edge   = (state_q != IDLE) & (finish_ok | timeout_hit);

   assign I_BUSYWAIT    = I_READ & ~i_done_q;
   assign D_BUSYWAIT    = (D_READ | D_WRITE) & ~d_done_q;
   assign I_READDATA    = i_rdata_q;
   assign D_READDATA    = d_rdata_q;
   assign MEM_READ      = mem_read_q;
   assign MEM_WRITE     = mem_write_q;
   assign MEM_ADDRESS   = mem_addr_q;
   assign MEM_WRITEDATA = mem_wdata_q;
   assign TIMEOUT_ERR   = tmo_q;

   // State register
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (grant_d)      state_d = SERVE_D;
            else if (grant_i) state_d = SERVE_I;
         end
         SERVE_I, SERVE_D: begin
            if (done_edge) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Output / datapath next-state logic
   always_comb begin
      mem_read_d  = mem_read_q;
      mem_write_d = mem_write_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      i_rdata_d   = i_rdata_q;
      d_rdata_d   = d_rdata_q;
      i_done_d    = 1'b0;
      d_done_d    = 1'b0;
      started_d   = started_q;
      cnt_d       = cnt_q;
      tmo_d       = tmo_q;
      last_d_d    = last_d_q;

      if (state_q == IDLE) begin
         if (grant_d) begin
            // Read and write together is illegal; the write wins.
            mem_read_d  = ~D_WRITE;
            mem_write_d = D_WRITE;
            mem_addr_d  = D_ADDRESS;
            if (D_WRITE) mem_wdata_d = D_WRITEDATA;
            last_d_d    = 1'b1;
            cnt_d       = '0;
            started_d   = 1'b0;
         end else if (grant_i) begin
            mem_read_d  = 1'b1;
            mem_write_d = 1'b0;
            mem_addr_d  = I_ADDRESS;
            last_d_d    = 1'b0;
            cnt_d       = '0;
            started_d   = 1'b0;
         end
      end else begin
         cnt_d = cnt_q + CW'(1);
         if (MEM_BUSYWAIT) started_d = 1'b1;
         if (done_edge) begin
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
            if (!finish_ok) tmo_d = 1'b1;
            if (state_q == SERVE_I) begin
               i_done_d  = 1'b1;
               i_rdata_d = finish_ok ? MEM_READDATA : '0;
            end else begin
               d_done_d = 1'b1;
               if (!finish_ok)     d_rdata_d = '0;
               else if (mem_read_q) d_rdata_d = MEM_READDATA;
            end
         end
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         i_rdata_q   <= '0;
         d_rdata_q   <= '0;
         i_done_q    <= 1'b0;
         d_done_q    <= 1'b0;
         started_q   <= 1'b0;
         cnt_q       <= '0;
         tmo_q       <= 1'b0;
         last_d_q    <= 1'b0;
      end else begin
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         i_rdata_q   <= i_rdata_d;
         d_rdata_q   <= d_rdata_d;
         i_done_q    <= i_done_d;
         d_done_q    <= d_done_d;
         started_q   <= started_d;
         cnt_q       <= cnt_d;
         tmo_q       <= tmo_d;
         last_d_q    <= last_d_d;
      end
   end

endmodule

// File: tb/tb_memory_arbiter.sv
// -----------------------------------------------------------------------------
// tb_memory_arbiter
//   Directed scenarios followed by a randomized two-requester run. A small
//   behavioural memory answers commands after a programmable latency; the
//   caches are modelled as agents holding a request until busywait drops.
//   Expected read data comes from address-derived contents plus a record of
//   completed D write-backs; fairness is checked as "at most one transaction
//   of the other side completes while a request waits".
// -----------------------------------------------------------------------------
module tb_memory_arbiter;

   logic         CLK = 1'b0;
   logic         RESET;
   logic         I_READ, D_READ, D_WRITE;
   logic [27:0]  I_ADDRESS, D_ADDRESS;
   logic [127:0] D_WRITEDATA;
   logic [127:0] I_READDATA, D_READDATA;
   logic         I_BUSYWAIT, D_BUSYWAIT;
   logic         MEM_READ, MEM_WRITE;
   logic [27:0]  MEM_ADDRESS;
   logic [127:0] MEM_WRITEDATA;
   logic [127:0] MEM_READDATA = '0;
   logic         MEM_BUSYWAIT = 1'b0;
   logic         TIMEOUT_ERR;

   int total = 0;
   int bad   = 0;

   memory_arbiter dut (
      .CLK(CLK), .RESET(RESET),
      .I_READ(I_READ), .I_ADDRESS(I_ADDRESS), .I_READDATA(I_READDATA), .I_BUSYWAIT(I_BUSYWAIT),
      .D_READ(D_READ), .D_WRITE(D_WRITE), .D_ADDRESS(D_ADDRESS), .D_WRITEDATA(D_WRITEDATA),
      .D_READDATA(D_READDATA), .D_BUSYWAIT(D_BUSYWAIT),
      .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDRESS(MEM_ADDRESS),
      .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT),
      .TIMEOUT_ERR(TIMEOUT_ERR)
   );

   always #5 CLK = ~CLK;

   task automatic chkb(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chki(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chkw(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Default memory contents derived from the address.
   function automatic logic [127:0] fdat(input logic [27:0] a);
      return {4{4'h5, a}};
   endfunction

   // ---------------- behavioural memory ----------------
   logic [127:0] memst [logic [27:0]];
   int           mem_lat = 3;
   bit           rnd_lat = 1'b0;
   bit           stuck   = 1'b0;
   int           mcnt    = 0;
   bit           mhold   = 1'b0;
   logic [27:0]  ca;
   logic         cwr;
   logic [127:0] cwd;

   always @(negedge CLK or posedge RESET) begin
      if (RESET) begin
         MEM_BUSYWAIT = 1'b0;
         mcnt  = 0;
         mhold = 1'b0;
      end else if (mhold) begin
         if (!MEM_READ && !MEM_WRITE) mhold = 1'b0;
      end else if (mcnt > 0) begin
         if (!stuck) begin
            mcnt--;
            if (mcnt == 0) begin
               MEM_BUSYWAIT = 1'b0;
               if (cwr) memst[ca] = cwd;
               else     MEM_READDATA = memst.exists(ca) ? memst[ca] : fdat(ca);
               mhold = 1'b1;
            end
         end
      end else if (MEM_READ || MEM_WRITE) begin
         ca  = MEM_ADDRESS;
         cwr = MEM_WRITE;
         cwd = MEM_WRITEDATA;
         chkb("mem_cmd_excl", MEM_READ & MEM_WRITE, 1'b0);
         if (MEM_WRITE) begin
            chkb("mem_wr_req", D_WRITE, 1'b1);
            chkw("mem_wr_addr", 128'(MEM_ADDRESS), 128'(D_ADDRESS));
            chkw("mem_wr_data", MEM_WRITEDATA, D_WRITEDATA);
         end else begin
            chkb("mem_rd_req", (I_READ && MEM_ADDRESS == I_ADDRESS) ||
                               (D_READ && !D_WRITE && MEM_ADDRESS == D_ADDRESS), 1'b1);
         end
         mcnt = rnd_lat ? int'($urandom_range(1, 4)) : mem_lat;
         MEM_BUSYWAIT = 1'b1;
      end
   end

   // ---------------- helpers ----------------
   task automatic wait_low(input bit dside, input int bound, output int n);
      n = 0;
      do begin
         @(negedge CLK);
         n++;
      end while ((dside ? D_BUSYWAIT : I_BUSYWAIT) && n < bound);
   endtask

   task automatic wait_grant(input string tag);
      int n = 0;
      do begin
         @(negedge CLK);
         n++;
      end while (!(MEM_READ || MEM_WRITE) && n < 20);
      chkb(tag, MEM_READ | MEM_WRITE, 1'b1);
   endtask

   // ---------------- stimulus ----------------
   logic [127:0] dmod [logic [27:0]];
   logic [127:0] wd, drd_prev;
   int  n, ni, nd, igap, dgap, i_other, d_other;
   bit  fin, dside;
   localparam int NTX = 40;

   initial begin
      RESET = 1'b1; I_READ = 1'b0; D_READ = 1'b0; D_WRITE = 1'b0;
      I_ADDRESS = '0; D_ADDRESS = '0; D_WRITEDATA = '0;
      memst[28'h0000010] = {16{8'hA5}};
      repeat (2) @(negedge CLK);
      chkb("rst_mem_read", MEM_READ, 1'b0);
      chkb("rst_mem_write", MEM_WRITE, 1'b0);
      chkw("rst_mem_addr", 128'(MEM_ADDRESS), '0);
      chkw("rst_mem_wdata", MEM_WRITEDATA, '0);
      chkw("rst_i_rdata", I_READDATA, '0);
      chkw("rst_d_rdata", D_READDATA, '0);
      chkb("rst_tmo", TIMEOUT_ERR, 1'b0);
      chkb("rst_bw", I_BUSYWAIT | D_BUSYWAIT, 1'b0);
      RESET = 1'b0;

      // 1: single I read, latency 3
      @(negedge CLK);
      I_ADDRESS = 28'h0000010; I_READ = 1'b1; mem_lat = 3;
      #1 chkb("t1_bw_req", I_BUSYWAIT, 1'b1);
      @(negedge CLK);
      chkb("t1_mem_read", MEM_READ, 1'b1);
      chkb("t1_mem_write", MEM_WRITE, 1'b0);
      chkw("t1_mem_addr", 128'(MEM_ADDRESS), 128'(28'h0000010));
      wait_low(1'b0, 20, n);
      chki("t1_latency", n, 4);
      chkw("t1_rdata", I_READDATA, {16{8'hA5}});
      chkb("t1_cmd_clr", MEM_READ, 1'b0);
      @(posedge CLK);
      #1 chkb("t1_bw_low_one_cycle", I_BUSYWAIT, 1'b1);
      I_READ = 1'b0;
      @(negedge CLK);
      chkb("t1_no_regrant", MEM_READ, 1'b0);

      // 2: simultaneous requests after reset -> D first, I at edge after D_DONE
      RESET = 1'b1;
      @(negedge CLK);
      RESET = 1'b0; mem_lat = 2;
      I_ADDRESS = 28'h0000020; D_ADDRESS = 28'h8000300;
      I_READ = 1'b1; D_READ = 1'b1;
      wait_grant("t2_grant");
      chkw("t2_first_d", 128'(MEM_ADDRESS), 128'(28'h8000300));
      wait_low(1'b1, 20, n);
      chkb("t2_d_done", D_BUSYWAIT, 1'b0);
      chkw("t2_d_rdata", D_READDATA, fdat(28'h8000300));
      chkb("t2_i_waiting", I_BUSYWAIT, 1'b1);
      @(posedge CLK);
      #1 D_READ = 1'b0;
      @(negedge CLK);
      chkb("t2_i_grant", MEM_READ, 1'b1);
      chkw("t2_i_addr", 128'(MEM_ADDRESS), 128'(28'h0000020));
      wait_low(1'b0, 20, n);
      chkw("t2_i_rdata", I_READDATA, fdat(28'h0000020));
      @(posedge CLK);
      #1 I_READ = 1'b0;

      // 3: back-to-back I_READ / D_WRITE -> D,I,D,I
      drd_prev = fdat(28'h8000300);
      I_ADDRESS = 28'h0000030; I_READ = 1'b1;
      D_ADDRESS = 28'h8000100; D_WRITEDATA = {$urandom, $urandom, $urandom, $urandom}; D_WRITE = 1'b1;
      for (int k = 0; k < 4; k++) begin
         dside = (k % 2 == 0);
         wait_grant("t3_grant");
         chkb("t3_side", MEM_WRITE, dside);
         chkw("t3_addr", 128'(MEM_ADDRESS), 128'(dside ? D_ADDRESS : I_ADDRESS));
         if (dside) chkw("t3_wdata", MEM_WRITEDATA, D_WRITEDATA);
         wait_low(dside, 20, n);
         chkb("t3_done", dside ? D_BUSYWAIT : I_BUSYWAIT, 1'b0);
         if (dside) chkw("t3_d_rdata_kept", D_READDATA, drd_prev);
         else       chkw("t3_i_rdata", I_READDATA, fdat(I_ADDRESS));
         @(posedge CLK);
         #1;
         if (k >= 2) begin
            if (dside) D_WRITE = 1'b0; else I_READ = 1'b0;
         end else if (dside) begin
            D_ADDRESS = D_ADDRESS + 28'd1;
            D_WRITEDATA = {$urandom, $urandom, $urandom, $urandom};
         end else begin
            I_ADDRESS = I_ADDRESS + 28'd1;
         end
      end

      // 4: memory stuck busy -> watchdog abort after 255 cycles in SERVE
      stuck = 1'b1;
      D_ADDRESS = 28'h8000400; D_READ = 1'b1;
      wait_grant("t4_grant");
      wait_low(1'b1, 400, n);
      chki("t4_abort_cycles", n, 255);
      chkw("t4_d_rdata_zero", D_READDATA, '0);
      chkb("t4_tmo", TIMEOUT_ERR, 1'b1);
      chkb("t4_cmd_clr", MEM_READ, 1'b0);
      @(posedge CLK);
      #1 D_READ = 1'b0;
      repeat (3) @(negedge CLK);
      chkb("t4_tmo_sticky", TIMEOUT_ERR, 1'b1);
      stuck = 1'b0;
      RESET = 1'b1;
      #1 chkb("t4_tmo_cleared", TIMEOUT_ERR, 1'b0);
      @(negedge CLK);
      RESET = 1'b0;

      // 5: reset during the second busy cycle of an I read
      mem_lat = 4;
      I_ADDRESS = 28'h0000040; I_READ = 1'b1;
      wait_grant("t5_grant");
      @(negedge CLK);
      #1 RESET = 1'b1;
      #1;
      chkb("t5_mem_read_drop", MEM_READ, 1'b0);
      chkw("t5_mem_addr_rst", 128'(MEM_ADDRESS), '0);
      chkb("t5_i_bw_follows", I_BUSYWAIT, 1'b1);
      chkb("t5_d_bw", D_BUSYWAIT, 1'b0);
      @(negedge CLK);
      RESET = 1'b0;
      @(negedge CLK);
      chkb("t5_regrant", MEM_READ, 1'b1);
      chkw("t5_regrant_addr", 128'(MEM_ADDRESS), 128'(28'h0000040));
      wait_low(1'b0, 20, n);
      chkw("t5_i_rdata", I_READDATA, fdat(28'h0000040));
      @(posedge CLK);
      #1 I_READ = 1'b0;

      // 6: D_READ & D_WRITE together is served as a write
      mem_lat = 2;
      D_ADDRESS = 28'h8000300; D_READ = 1'b1;
      wait_grant("t6_rd_grant");
      wait_low(1'b1, 20, n);
      chkw("t6_d_rdata", D_READDATA, fdat(28'h8000300));
      @(posedge CLK);
      #1;
      wd = {$urandom, $urandom, $urandom, $urandom};
      D_ADDRESS = 28'h8000200; D_WRITEDATA = wd; D_WRITE = 1'b1;
      wait_grant("t6_wr_grant");
      chkb("t6_mem_write", MEM_WRITE, 1'b1);
      chkb("t6_mem_read", MEM_READ, 1'b0);
      chkw("t6_mem_wdata", MEM_WRITEDATA, wd);
      wait_low(1'b1, 20, n);
      chkw("t6_d_rdata_kept", D_READDATA, fdat(28'h8000300));
      chkw("t6_mem_stored", memst.exists(28'h8000200) ? memst[28'h8000200] : '0, wd);
      @(posedge CLK);
      #1 begin D_READ = 1'b0; D_WRITE = 1'b0; end

      // Randomized two-agent traffic
      RESET = 1'b1;
      @(negedge CLK);
      RESET = 1'b0; rnd_lat = 1'b1;
      ni = 0; nd = 0; igap = 0; dgap = 0; i_other = 0; d_other = 0;
      fin = 1'b0; drd_prev = '0;
      for (int cyc = 0; cyc < 8000 && !fin; cyc++) begin
         @(negedge CLK);
         if (I_READ) begin
            if (!I_BUSYWAIT) begin
               chkw("rnd_i_rdata", I_READDATA, fdat(I_ADDRESS));
               chkb("rnd_i_fair", i_other <= 1, 1'b1);
               I_READ = 1'b0; ni++; d_other++;
               igap = $urandom_range(0, 3);
            end
         end else if (igap > 0) begin
            igap--;
         end else if (ni < NTX) begin
            I_ADDRESS = {2'b01, 23'd0, 3'($urandom_range(0, 7))};
            I_READ = 1'b1; i_other = 0;
         end

         if (D_READ || D_WRITE) begin
            if (!D_BUSYWAIT) begin
               if (D_WRITE) begin
                  dmod[D_ADDRESS] = D_WRITEDATA;
                  chkw("rnd_d_rdata_kept", D_READDATA, drd_prev);
               end else begin
                  drd_prev = dmod.exists(D_ADDRESS) ? dmod[D_ADDRESS] : fdat(D_ADDRESS);
                  chkw("rnd_d_rdata", D_READDATA, drd_prev);
               end
               chkb("rnd_d_fair", d_other <= 1, 1'b1);
               D_READ = 1'b0; D_WRITE = 1'b0; nd++; i_other++;
               dgap = $urandom_range(0, 3);
            end
         end else if (dgap > 0) begin
            dgap--;
         end else if (nd < NTX) begin
            n = $urandom_range(0, 7);
            D_ADDRESS = {1'b1, 24'd0, 3'($urandom_range(0, 7))};
            D_WRITEDATA = {$urandom, $urandom, $urandom, $urandom};
            D_READ  = (n < 4) || (n == 7);
            D_WRITE = (n >= 4);
            d_other = 0;
         end

         if (ni >= NTX && nd >= NTX && !I_READ && !D_READ && !D_WRITE) fin = 1'b1;
      end
      chkb("rnd_all_done", fin, 1'b1);
      chkb("rnd_no_timeout", TIMEOUT_ERR, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
